// File: rtl/sdram_init_param.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_param
// Purpose  : Parametrised SDRAM power-up initialisation sequencer. Drives the
//            command/bank/address buses of the controller mux through
//            WAIT -> PRECHARGE -> n x AUTO REFRESH -> MRS [-> EMRS] -> END.
//            A re-initialisation request seen in END replays the command
//            sequence without repeating the power-up wait.
// Option   : `define SDRAM_INIT_EMRS_EN adds Extended Mode Register
//            programming (bank 2, address EMRS_VAL) after the MRS.
// Ports    : init_clk   - system clock
//            init_rst_n - asynchronous active-low reset
//            init_req   - re-initialisation request (single-cycle pulse)
//            init_cmd   - {CS#,RAS#,CAS#,WE#}
//            init_bank  - bank address
//            init_addr  - address bus
//            init_busy  - high while the sequence is running
//            init_end   - high once initialisation is complete
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_param #(
    parameter int         T_WAIT_CYC   = 10000,
    parameter int         AR_NUM       = 2,
    parameter int         TRP_CYC      = 2,
    parameter int         TRFC_CYC     = 8,
    parameter int         TMRD_CYC     = 3,
    parameter int         ADDR_W       = 13,
    parameter int         BA_W         = 2,
    parameter int         CAS_LAT      = 3,
    parameter int         BURST_TYPE   = 0,
    parameter logic [2:0] BURST_LEN    = 3'b111,
    parameter int         WRITE_SINGLE = 0
`ifdef SDRAM_INIT_EMRS_EN
    ,
    parameter logic [ADDR_W-1:0] EMRS_VAL = '0
`endif
) (
    input  logic              init_clk,
    input  logic              init_rst_n,
    input  logic              init_req,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_bank,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              init_end
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [3:0] c_CMD_NOP = 4'b0111;
    localparam logic [3:0] c_CMD_PRE = 4'b0010;
    localparam logic [3:0] c_CMD_AR  = 4'b0001;
    localparam logic [3:0] c_CMD_MRS = 4'b0000;

    localparam int c_CYC_MAX_A = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int c_CYC_MAX   = (c_CYC_MAX_A > TMRD_CYC) ? c_CYC_MAX_A : TMRD_CYC;
    localparam int c_CYC_W     = $clog2(c_CYC_MAX + 1);
    localparam int c_REF_W     = $clog2(AR_NUM + 1);
    localparam int c_WAIT_W    = $clog2(T_WAIT_CYC + 1);

    localparam logic [c_CYC_W-1:0]  c_TRP_LAST  = c_CYC_W'(TRP_CYC - 1);
    localparam logic [c_CYC_W-1:0]  c_TRFC_LAST = c_CYC_W'(TRFC_CYC - 1);
    localparam logic [c_CYC_W-1:0]  c_TMRD_LAST = c_CYC_W'(TMRD_CYC - 1);
    localparam logic [c_REF_W-1:0]  c_AR_NUM    = c_REF_W'(AR_NUM);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(T_WAIT_CYC - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(T_WAIT_CYC);

    // Mode register: {reserved, A9 write mode, A8..A7 = 0, A6..A4 CAS,
    // A3 burst type, A2..A0 burst length}
    localparam logic [ADDR_W-1:0] c_MRS_ADDR = {
        {(ADDR_W - 10){1'b0}},
        1'(WRITE_SINGLE),
        2'b00,
        3'(CAS_LAT),
        1'(BURST_TYPE),
        BURST_LEN
    };

`ifdef SDRAM_INIT_EMRS_EN
    // BA1 = 1, BA0 = 0 selects the extended mode register.
    localparam logic [BA_W-1:0] c_EMRS_BANK = BA_W'(2);
`endif

    generate
        if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_cas_lat_check
            $error("sdram_init_param: CAS_LAT must be 2 or 3");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,
        S_PRE   = 4'd1,
        S_TRP   = 4'd2,
        S_AR    = 4'd3,
        S_TRFC  = 4'd4,
        S_MRS   = 4'd5,
        S_TMRD  = 4'd6,
        S_END   = 4'd7
`ifdef SDRAM_INIT_EMRS_EN
        ,
        S_EMRS  = 4'd8,
        S_TEMRD = 4'd9
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CYC_W-1:0]  r_cyc_cnt;
    logic [c_CYC_W-1:0]  w_cyc_nxt;
    logic [c_REF_W-1:0]  r_ref_cnt;
    logic [c_REF_W-1:0]  w_ref_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic [3:0]          r_cmd;
    logic [BA_W-1:0]     r_bank;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_end;
    logic                r_busy;

    logic [3:0]          w_cmd_nxt;
    logic [BA_W-1:0]     w_bank_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_end_nxt;

    // ------------------------------------------------------------------
    // Next-state, counter and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc_cnt;
        w_ref_nxt   = r_ref_cnt;
        w_cmd_nxt   = c_CMD_NOP;
        w_bank_nxt  = '1;
        w_addr_nxt  = '1;
        w_end_nxt   = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = S_PRE;
                    w_cyc_nxt   = '0;
                    w_ref_nxt   = '0;
                end
            end

            S_PRE: begin
                // All-ones address keeps A10 high: precharge all banks.
                w_cmd_nxt   = c_CMD_PRE;
                w_state_nxt = S_TRP;
                w_cyc_nxt   = '0;
            end

            S_TRP: begin
                if (r_cyc_cnt == c_TRP_LAST) begin
                    w_state_nxt = S_AR;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc_cnt + c_CYC_W'(1);
                end
            end

            S_AR: begin
                w_cmd_nxt   = c_CMD_AR;
                w_ref_nxt   = r_ref_cnt + c_REF_W'(1);
                w_state_nxt = S_TRFC;
                w_cyc_nxt   = '0;
            end

            S_TRFC: begin
                if (r_cyc_cnt == c_TRFC_LAST) begin
                    w_state_nxt = (r_ref_cnt == c_AR_NUM) ? S_MRS : S_AR;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc_cnt + c_CYC_W'(1);
                end
            end

            S_MRS: begin
                w_cmd_nxt   = c_CMD_MRS;
                w_bank_nxt  = '0;
                w_addr_nxt  = c_MRS_ADDR;
                w_state_nxt = S_TMRD;
                w_cyc_nxt   = '0;
            end

            S_TMRD: begin
                if (r_cyc_cnt == c_TMRD_LAST) begin
`ifdef SDRAM_INIT_EMRS_EN
                    w_state_nxt = S_EMRS;
`else
                    w_state_nxt = S_END;
`endif
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc_cnt + c_CYC_W'(1);
                end
            end

`ifdef SDRAM_INIT_EMRS_EN
            S_EMRS: begin
                w_cmd_nxt   = c_CMD_MRS;
                w_bank_nxt  = c_EMRS_BANK;
                w_addr_nxt  = EMRS_VAL;
                w_state_nxt = S_TEMRD;
                w_cyc_nxt   = '0;
            end

            S_TEMRD: begin
                if (r_cyc_cnt == c_TMRD_LAST) begin
                    w_state_nxt = S_END;
                    w_cyc_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc_cnt + c_CYC_W'(1);
                end
            end
`endif

            S_END: begin
                // A request drops init_end on the same edge it is sampled,
                // and the sequence restarts at PRECHARGE (no power-up wait).
                w_end_nxt = ~init_req;
                if (init_req) begin
                    w_state_nxt = S_PRE;
                    w_cyc_nxt   = '0;
                    w_ref_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = S_WAIT;
                w_cyc_nxt   = '0;
                w_ref_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            r_state    <= S_WAIT;
            r_cyc_cnt  <= '0;
            r_ref_cnt  <= '0;
            r_wait_cnt <= '0;
            r_cmd      <= c_CMD_NOP;
            r_bank     <= '1;
            r_addr     <= '1;
            r_end      <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc_cnt <= w_cyc_nxt;
            r_ref_cnt <= w_ref_nxt;
            // Saturates so a re-initialisation never re-enters the wait.
            if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end
            r_cmd  <= w_cmd_nxt;
            r_bank <= w_bank_nxt;
            r_addr <= w_addr_nxt;
            r_end  <= w_end_nxt;
            r_busy <= ~w_end_nxt;
        end
    end

    assign init_cmd  = r_cmd;
    assign init_bank = r_bank;
    assign init_addr = r_addr;
    assign init_end  = r_end;
    assign init_busy = r_busy;

endmodule
`default_nettype wire

// File: doc/sdram_init_param.md
Name: sdram_init_param

Overview:
Parametrised SDRAM power-up initialisation sequencer. It drives the command, bank and address buses of the SDRAM controller mux until init_end is raised. Relative to the fixed-timing initialiser, it adds:
- configurable timing, refresh count and mode-register fields;
- configurable address and bank widths;
- a re-initialisation request that skips the power-up wait;
- optional Extended Mode Register programming for mobile SDRAM.

Parameters:
- T_WAIT_CYC, 10000: power-up wait in init_clk cycles (100 us at 100 MHz); ≥ 2.
- AR_NUM, 2: number of AUTO REFRESH commands; ≥ 1.
- TRP_CYC, 2: NOP cycles after PRECHARGE; ≥ 1.
- TRFC_CYC, 8: NOP cycles after each AUTO REFRESH; ≥ 1.
- TMRD_CYC, 3: NOP cycles after each (E)MRS; ≥ 1.
- ADDR_W, 13: SDRAM address width; ≥ 11.
- BA_W, 2: bank address width; ≥ 1.
- CAS_LAT, 3: CAS latency field A6..A4; only 2 or 3 are legal, other values are a parameter error.
- BURST_TYPE, 0: A3; 0 = sequential, 1 = interleaved.
- BURST_LEN, 3'b111: A2..A0 code (3'b111 = full page).
- WRITE_SINGLE, 0: A9; 0 = burst write, 1 = single write.
- EMRS_VAL, 13'h0000: EMRS address value (used only with the macro enabled).

Ports:
- init_clk  in  1  system clock, 100 MHz
- init_rst_n  in  1  asynchronous reset, active-low
- init_req  in  1  re-initialisation request; single-cycle pulse
- init_cmd  out  4  {CS#,RAS#,CAS#,WE#}
- init_bank  out  BA_W  bank address
- init_addr  out  ADDR_W  address bus
- init_busy  out  1  high while the sequence is running
- init_end  out  1  high when initialisation is complete

Behaviour:
- Reset is init_rst_n, asynchronous, active-low; clock is init_clk.
- Reset values:
  - init_cmd = NOP (4'b0111);
  - init_bank and init_addr = all ones;
  - init_end = 0, init_busy = 1;
  - state = WAIT; all counters = 0.
- Commands: PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, MRS 4'b0000, NOP 4'b0111.
- All outputs are registered and lag the state by one cycle.
- Every non-NOP command is held for exactly one cycle.
- Non-command cycles carry NOP with bank and address all ones.
- PRECHARGE carries all-ones address (A10 = 1, all banks).
- State sequence: WAIT → PRE → TRP → AR → TRFC → {AR | MRS} → TMRD → [EMRS → TEMRD] → END.
- WAIT: a wait counter increments each cycle from reset release and saturates at T_WAIT_CYC. Exit to PRE on the edge where the counter equals T_WAIT_CYC-1. PRECHARGE therefore appears on init_cmd at rising edge T_WAIT_CYC+1, counting edge 1 as the first edge with init_rst_n high.
- Command spacing, issue to issue: PRE→AR is TRP_CYC+1 cycles; AR→AR and AR→MRS are TRFC_CYC+1 cycles.
- The refresh counter counts AR states. TRFC exits to MRS when the counter equals AR_NUM, otherwise to AR. Counter width is clog2(AR_NUM+1).
- MRS drives init_bank = 0 and init_addr as follows:
  - init_addr[ADDR_W-1:10] = 0;
  - init_addr[9] = WRITE_SINGLE;
  - init_addr[8:7] = 0;
  - init_addr[6:4] = CAS_LAT;
  - init_addr[3] = BURST_TYPE;
  - init_addr[2:0] = BURST_LEN.
- init_end rises TMRD_CYC+1 cycles after the MRS cycle on init_cmd (extended when the EMRS option is enabled).
- init_end stays high in END; init_busy = ~init_end.
- init_req handling:
  - Sampled only in END; ignored in every other state, with no queuing.
  - When seen in END: init_end falls and init_busy rises on that same edge, and the state moves to PRE.
  - The power-up wait is not repeated, so PRECHARGE appears on the next edge.
  - The refresh counter clears on entry to PRE.
- Asserting reset mid-sequence aborts immediately: outputs return to reset values and the full T_WAIT_CYC wait restarts.
- The per-state cycle counter clears on every state exit and never exceeds max(TRP_CYC, TRFC_CYC, TMRD_CYC).
- Illegal state encodings recover to WAIT.

Optional Feature:
- Macro: SDRAM_INIT_EMRS_EN.
- When defined: after TMRD, the block enters EMRS for one cycle and issues MRS with init_bank = 2 (BA1 = 1, BA0 = 0; upper bank bits 0) and init_addr = EMRS_VAL[ADDR_W-1:0]. It then holds NOP for TMRD_CYC cycles before END, so init_end rises TMRD_CYC+1 cycles after the EMRS command.
- When undefined: the EMRS and TEMRD states and EMRS_VAL logic are absent, and TMRD goes directly to END.

Test Plan:
- Power-up with T_WAIT_CYC=20, defaults otherwise:
  - edges 1–20: NOP;
  - edge 21: PRECHARGE with init_addr=13'h1FFF;
  - edge 24: AUTO REFRESH;
  - edge 33: AUTO REFRESH;
  - edge 42: MRS with init_addr=13'h0037, init_bank=0;
  - edge 46: init_end=1 and init_busy=0.
- AR_NUM=4, TRFC_CYC=5, T_WAIT_CYC=20 → exactly 4 AUTO REFRESH commands, spaced 6 cycles apart, then MRS 6 cycles after the last one.
- CAS_LAT=2, BURST_LEN=3'b011, WRITE_SINGLE=1, BURST_TYPE=1 → MRS init_addr=13'h022B.
- 1-cycle init_req pulse 10 cycles after init_end → init_end falls on the sampling edge, PRECHARGE on the next edge, no 20-cycle wait, init_end returns after the full command sequence. An init_req pulse mid-sequence (during TRFC) → no effect on timing.
- Reset asserted during the second TRFC → init_cmd=NOP and init_end=0 immediately; after release, PRECHARGE again at edge T_WAIT_CYC+1.
- With SDRAM_INIT_EMRS_EN and EMRS_VAL=13'h0020: an MRS with init_bank=2 and init_addr=13'h0020 follows the normal MRS by TMRD_CYC+1 cycles, and init_end rises TMRD_CYC+1 cycles after the EMRS.
